serial_rr_arbiter: RTL

Round-robin arbiter that shares the single serial deserializer input between N_SRC independent bit-serial senders. It grants one sender at a time and forwards that sender's bit/write strobes to the deserializer. It holds the grant until the 8-bit byte has been accepted downstream (data_ready high then low), then tags the byte with its source index. A stalled or abandoned transfer is aborted via a one-cycle flush pulse to the deserializer.

---
 rtl/serial_pkg.sv | 16 +
 rtl/serial_rr_arbiter_rr_pick.sv | 35 +++
 rtl/serial_rr_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared types and constants for the serial round-robin arbiter.
// Imported by the arbiter top and its priority selector.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        FLUSH  = 3'd4
    } arb_state_t;

    localparam int BYTE_BITS     = 8;
    localparam int ABORT_CNT_MAX = 255;

endpackage

// File: rtl/serial_rr_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request
// after the last granted index, wrapping modulo N_SRC.
module rr_pick
    import serial_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int SRC_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] i_req,
    input  logic [SRC_W-1:0] i_last_grant,
    output logic             o_found,
    output logic [SRC_W-1:0] o_idx,
    output logic [N_SRC-1:0] o_onehot
);

    logic [SRC_W-1:0] w_pos;

    always_comb begin
        o_found  = 1'b0;
        o_idx    = '0;
        o_onehot = '0;
        w_pos    = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            w_pos = SRC_W'((int'(i_last_grant) + k) % N_SRC);
            if (!o_found && i_req[w_pos]) begin
                o_found = 1'b1;
                o_idx   = w_pos;
            end
        end
        if (o_found) begin
            o_onehot[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/serial_rr_arbiter.sv
// Round-robin arbiter sharing one serial deserializer between
// N_SRC bit-serial senders, with source tagging and abort flush.
module serial_rr_arbiter
    import serial_pkg::*;
#(
    parameter int N_SRC       = 4,
    parameter int SRC_W       = $clog2(N_SRC),
    parameter int TIMEOUT_CYC = 32
) (
    input  logic             clock_100KHZ,
    input  logic             reset,
    input  logic [N_SRC-1:0] req,
    input  logic [N_SRC-1:0] bit_in,
    input  logic [N_SRC-1:0] wr_in,
    output logic [N_SRC-1:0] gnt,
    output logic             des_data_in,
    output logic             des_write_in,
    input  logic             des_status_in,
    input  logic             des_data_ready,
    output logic             des_flush,
    output logic [SRC_W-1:0] byte_src,
    output logic             byte_tag_valid,
    output logic [7:0]       abort_count,
    output logic [2:0]       state_out
);

    localparam int IW = $clog2(TIMEOUT_CYC + 1);

    arb_state_t       r_state;
    logic [SRC_W-1:0] r_sel;
    logic [N_SRC-1:0] r_gnt;
    logic [SRC_W-1:0] r_last_grant;
    logic [3:0]       r_bit_cnt;
    logic [IW-1:0]    r_idle_cnt;
    logic [7:0]       r_abort_cnt;
    logic             r_rdy_seen;
    logic [SRC_W-1:0] r_byte_src;

    arb_state_t       w_state_nx;
    logic [SRC_W-1:0] w_sel_nx;
    logic [N_SRC-1:0] w_gnt_nx;
    logic [SRC_W-1:0] w_last_nx;
    logic [3:0]       w_bit_nx;
    logic [IW-1:0]    w_idle_nx;
    logic [7:0]       w_abort_nx;
    logic             w_rdy_seen_nx;
    logic [SRC_W-1:0] w_src_nx;

    logic             w_found;
    logic [SRC_W-1:0] w_idx;
    logic [N_SRC-1:0] w_onehot;
    logic             w_req_sel;
    logic             w_fwd;
    logic             w_last_bit;
    logic             w_timeout;

    rr_pick #(
        .N_SRC (N_SRC),
        .SRC_W (SRC_W)
    ) u_pick (
        .i_req        (req),
        .i_last_grant (r_last_grant),
        .o_found      (w_found),
        .o_idx        (w_idx),
        .o_onehot     (w_onehot)
    );

    assign w_req_sel  = req[r_sel];
    assign w_fwd      = (r_state == STREAM) & wr_in[r_sel] & des_status_in;
    assign w_last_bit = (r_bit_cnt == 4'(BYTE_BITS - 1));
    assign w_timeout  = (r_idle_cnt == IW'(TIMEOUT_CYC - 1));

    assign gnt            = r_gnt;
    assign des_write_in   = w_fwd;
    assign des_data_in    = (r_state == STREAM) & bit_in[r_sel];
    assign des_flush      = (r_state == FLUSH);
    assign byte_src       = r_byte_src;
    assign byte_tag_valid = (r_state == DRAIN) & des_data_ready;
    assign abort_count    = r_abort_cnt;
    assign state_out      = r_state;

    always_comb begin
        w_state_nx    = r_state;
        w_sel_nx      = r_sel;
        w_gnt_nx      = r_gnt;
        w_last_nx     = r_last_grant;
        w_bit_nx      = r_bit_cnt;
        w_idle_nx     = r_idle_cnt;
        w_abort_nx    = r_abort_cnt;
        w_rdy_seen_nx = r_rdy_seen;
        w_src_nx      = r_byte_src;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_sel_nx   = w_idx;
                    w_gnt_nx   = w_onehot;
                    w_state_nx = ARM;
                end
            end
            ARM: begin
                if (!w_req_sel) begin
                    w_state_nx = FLUSH;
                end else if (des_status_in) begin
                    w_state_nx = STREAM;
                end
            end
            STREAM: begin
                // a write in the same cycle as the timeout still counts
                if (w_fwd) begin
                    w_bit_nx  = r_bit_cnt + 4'd1;
                    w_idle_nx = '0;
                    if (w_last_bit) begin
                        w_state_nx    = DRAIN;
                        w_src_nx      = r_sel;
                        w_rdy_seen_nx = 1'b0;
                    end else if (!w_req_sel) begin
                        w_state_nx = FLUSH;
                    end
                end else if (!w_req_sel || w_timeout) begin
                    w_state_nx = FLUSH;
                end else begin
                    w_idle_nx = r_idle_cnt + IW'(1);
                end
            end
            DRAIN: begin
                if (des_data_ready) begin
                    w_rdy_seen_nx = 1'b1;
                end else if (r_rdy_seen) begin
                    w_state_nx    = IDLE;
                    w_last_nx     = r_sel;
                    w_gnt_nx      = '0;
                    w_bit_nx      = '0;
                    w_idle_nx     = '0;
                    w_rdy_seen_nx = 1'b0;
                end
            end
            FLUSH: begin
                w_state_nx    = IDLE;
                w_last_nx     = r_sel;
                w_gnt_nx      = '0;
                w_bit_nx      = '0;
                w_idle_nx     = '0;
                w_rdy_seen_nx = 1'b0;
                if (r_abort_cnt != 8'(ABORT_CNT_MAX)) begin
                    w_abort_nx = r_abort_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_gnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clock_100KHZ or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_sel        <= '0;
            r_gnt        <= '0;
            r_last_grant <= SRC_W'(N_SRC - 1);
            r_bit_cnt    <= '0;
            r_idle_cnt   <= '0;
            r_abort_cnt  <= '0;
            r_rdy_seen   <= 1'b0;
            r_byte_src   <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_sel        <= w_sel_nx;
            r_gnt        <= w_gnt_nx;
            r_last_grant <= w_last_nx;
            r_bit_cnt    <= w_bit_nx;
            r_idle_cnt   <= w_idle_nx;
            r_abort_cnt  <= w_abort_nx;
            r_rdy_seen   <= w_rdy_seen_nx;
            r_byte_src   <= w_src_nx;
        end
    end

endmodule
